// File: rtl/adder_sixty_four_bit_pkg.sv
// Shared widths and types for the 64-bit carry-lookahead adder.
package adder_pkg;

    localparam int ADDER_WIDTH = 64;
    localparam int CLA_BLK     = 4;

    typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage

// File: rtl/adder_sixty_four_bit_if.sv
// Operand/result bundle between the datapath and the adder.
interface adder_sixty_four_bit_if
    import adder_pkg::*;
;

    word_t a;
    word_t b;
    word_t sum;
    logic  cout;
    logic  ovrflow;
    word_t sum_q;
    logic  cout_q;
    logic  ovf_q;

    modport master (
        output a, b,
        input  sum, cout, ovrflow,
        input  sum_q, cout_q, ovf_q
    );

    modport slave (
        input  a, b,
        output sum, cout, ovrflow,
        output sum_q, cout_q, ovf_q
    );

endinterface

// File: rtl/adder_sixty_four_bit_cla_block.sv
// One carry-lookahead group: sum bits plus group propagate/generate.
module cla_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] i_p,
    input  logic [BLK-1:0] i_g,
    input  logic           i_cin,
    output logic [BLK-1:0] o_sum,
    output logic           o_gp,
    output logic           o_gg
);

    logic w_c;

    always_comb begin
        o_sum = '0;
        o_gp  = 1'b1;
        o_gg  = 1'b0;
        w_c   = i_cin;
        for (int i = 0; i < BLK; i++) begin
            o_sum[i] = i_p[i] ^ w_c;
            w_c      = i_g[i] | (i_p[i] & w_c);
            o_gp     = o_gp & i_p[i];
            // Group G ignores i_cin so the second level never waits on it.
            o_gg     = i_g[i] | (i_p[i] & o_gg);
        end
    end

endmodule

// File: rtl/adder_sixty_four_bit.sv
// Two-level carry-lookahead adder with registered status copies.
module adder_sixty_four_bit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int BLK   = CLA_BLK
) (
    input logic             clk,
    input logic             rst_n,
    adder_sixty_four_bit_if.slave bus
);

    localparam int NG = WIDTH / BLK;
    localparam int NS = (NG + BLK - 1) / BLK;

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_sum;
    logic [NG-1:0]    w_gp;
    logic [NG-1:0]    w_gg;
    logic [NG:0]      w_gc;
    logic [NS-1:0]    w_sp;
    logic [NS-1:0]    w_sg;
    logic [NS:0]      w_sc;
    logic             w_cout;
    logic             w_c_msb;
    logic             w_ovf;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    assign w_p = bus.a ^ bus.b;
    assign w_g = bus.a & bus.b;

    for (genvar j = 0; j < NG; j++) begin : g_blk
        cla_block #(
            .BLK (BLK)
        ) u_blk (
            .i_p   (w_p[j*BLK +: BLK]),
            .i_g   (w_g[j*BLK +: BLK]),
            .i_cin (w_gc[j]),
            .o_sum (w_sum[j*BLK +: BLK]),
            .o_gp  (w_gp[j]),
            .o_gg  (w_gg[j])
        );
    end

    always_comb begin
        w_sp = '1;
        w_sg = '0;
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < BLK; k++) begin
                if (s * BLK + k < NG) begin
                    w_sg[s] = w_gg[s*BLK+k] | (w_gp[s*BLK+k] & w_sg[s]);
                    w_sp[s] = w_sp[s] & w_gp[s*BLK+k];
                end
            end
        end
    end

    always_comb begin
        w_sc    = '0;
        w_sc[0] = 1'b0;
        for (int s = 0; s < NS; s++) begin
            w_sc[s+1] = w_sg[s] | (w_sp[s] & w_sc[s]);
        end
    end

    // Each supergroup restarts its group chain from its own lookahead carry.
    always_comb begin
        w_gc = '0;
        for (int j = 0; j < NG; j++) begin
            if (j % BLK == 0) begin
                w_gc[j] = w_sc[j/BLK];
            end else begin
                w_gc[j] = w_gg[j-1] | (w_gp[j-1] & w_gc[j-1]);
            end
        end
        w_gc[NG] = w_sc[NS];
    end

    assign w_cout  = w_gc[NG];
    assign w_c_msb = w_p[WIDTH-1] ^ w_sum[WIDTH-1];
    assign w_ovf   = w_c_msb ^ w_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
        end
    end

    assign bus.sum     = w_sum;
    assign bus.cout    = w_cout;
    assign bus.ovrflow = w_ovf;
    assign bus.sum_q   = r_sum;
    assign bus.cout_q  = r_cout;
    assign bus.ovf_q   = r_ovf;

endmodule

// File: tb/tb_adder_sixty_four_bit.sv
// Directed and random checks for the 64-bit CLA adder.
module tb_adder_sixty_four_bit;
    import adder_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    adder_sixty_four_bit_if bus ();

    adder_sixty_four_bit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(
        input string        tag,
        input logic [64:0]  got,
        input logic [64:0]  exp
    );
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        word_t a;
        word_t b;
        word_t s;
        logic  c;
        logic  v;
    } vec_t;

    vec_t vecs[8];

    initial begin
        word_t       ra;
        word_t       rb;
        logic [64:0] full;
        logic        m_ovf;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{64'h2, 64'h3, 64'h5, 1'b0, 1'b0};
        vecs[1] = '{64'h7, 64'h8, 64'hF, 1'b0, 1'b0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
                    64'h0, 1'b1, 1'b0};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[4] = '{64'h8000_0000_0000_0000,
                    64'h8000_0000_0000_0000,
                    64'h0, 1'b1, 1'b1};
        vecs[5] = '{64'h0, 64'h0, 64'h0, 1'b0, 1'b0};
        vecs[6] = '{64'h8000_0000_0000_0000,
                    64'hFFFF_FFFF_FFFF_FFFF,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[7] = '{64'h5555_5555_5555_5555,
                    64'hAAAA_AAAA_AAAA_AAAB,
                    64'h0, 1'b1, 1'b0};

        rst_n = 1'b0;
        bus.a = 64'h1234;
        bus.b = 64'h1;
        #12;
        check_val("rst_sum_q", {1'b0, bus.sum_q}, 65'h0);
        check_val("rst_flags_q",
                  {63'h0, bus.cout_q, bus.ovf_q}, 65'h0);
        check_val("rst_comb", {1'b0, bus.sum}, 65'h1235);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.a = vecs[i].a;
            bus.b = vecs[i].b;
            #1;
            check_val($sformatf("sum%0d", i),
                      {1'b0, bus.sum}, {1'b0, vecs[i].s});
            check_val($sformatf("flags%0d", i),
                      {63'h0, bus.cout, bus.ovrflow},
                      {63'h0, vecs[i].c, vecs[i].v});
            @(posedge clk);
            #1;
            check_val($sformatf("sum_q%0d", i),
                      {1'b0, bus.sum_q}, {1'b0, vecs[i].s});
            check_val($sformatf("flags_q%0d", i),
                      {63'h0, bus.cout_q, bus.ovf_q},
                      {63'h0, vecs[i].c, vecs[i].v});
        end

        // Mid-cycle async reset with a nonzero captured value.
        @(negedge clk);
        bus.a = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.b = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        check_val("pre_rst_q",
                  {bus.cout_q, bus.sum_q},
                  {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_sum_q", {1'b0, bus.sum_q}, 65'h0);
        check_val("arst_flags_q",
                  {63'h0, bus.cout_q, bus.ovf_q}, 65'h0);
        check_val("arst_comb",
                  {bus.cout, bus.sum},
                  {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rel_hold_q", {1'b0, bus.sum_q}, 65'h0);
        @(posedge clk);
        #1;
        check_val("rel_cap_q",
                  {bus.cout_q, bus.sum_q},
                  {1'b1, 64'hFFFF_FFFF_FFFF_FFFE});

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 4 == 1) rb = ~ra;
            if (i % 4 == 2) rb = (~ra) + 64'h1;
            bus.a = ra;
            bus.b = rb;
            full  = {1'b0, ra} + {1'b0, rb};
            m_ovf = (ra[63] == rb[63]) && (full[63] != ra[63]);
            #1;
            check_val("rnd_sum", {bus.cout, bus.sum}, full);
            check_val("rnd_ovf", {64'h0, bus.ovrflow},
                      {64'h0, m_ovf});
            @(posedge clk);
            #1;
            check_val("rnd_q", {bus.cout_q, bus.sum_q}, full);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 n_checks, n_fail);
        $finish;
    end

endmodule
